// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - FSM states and 2-bit JK excitation codes for jk_excite_gen
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Excitation codes are {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// rtl/jk_excite_bit.sv - per-bit (q, target) to (j, k) excitation; JK_TOGGLE_PREF_EN selects toggle for changing bits
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] jk;

    // Unchanged bits hold; changing bits use set/reset, or toggle in the toggle-preferring build
    always_comb begin
        jk = JK_HOLD;
        if (q != t) begin
`ifdef JK_TOGGLE_PREF_EN
            jk = JK_TGL;
`else
            jk = q ? JK_RST : JK_SET;
`endif
        end
    end

    assign j = jk[1];
    assign k = jk[0];

endmodule

// File: rtl/jk_excite_gen.sv
// rtl/jk_excite_gen.sv - drives a JK flip-flop bank to a requested state with feedback check and retry (JK_TOGGLE_PREF_EN via jk_excite_bit)
module jk_excite_gen
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       mismatch_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_reg;
    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             accept;
    logic             match;
    logic             retry_ok;

    assign accept   = tgt_valid && (state == IDLE);
    assign match    = (q_fb == tgt_reg);
    assign retry_ok = (mismatch_cnt < 3'(MAX_RETRY));

    // On accept the target is not latched yet, so excite from the incoming word
    assign exc_tgt = (state == IDLE) ? tgt_data : tgt_reg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit u_bit (
            .q (q_fb[i]),
            .t (exc_tgt[i]),
            .j (j_nxt[i]),
            .k (k_nxt[i])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one DRIVE cycle, one CHECK cycle, retry until match or budget spent
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = CHECK;
            CHECK:   state_nxt = (!match && retry_ok) ? DRIVE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs; a cycle with rst high never reports completion of an aborted target
    always_comb begin
        tgt_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == CHECK) && match && !rst;
        error     = (state == CHECK) && !match && !retry_ok && !rst;
    end

    // Excitation registers are loaded only on entry to DRIVE and are zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            j_out        <= '0;
            k_out        <= '0;
            tgt_reg      <= '0;
            mismatch_cnt <= '0;
        end else begin
            j_out <= '0;
            k_out <= '0;
            if (accept) begin
                tgt_reg      <= tgt_data;
                mismatch_cnt <= '0;
                j_out        <= j_nxt;
                k_out        <= k_nxt;
            end else if (state == CHECK && !match && retry_ok) begin
                mismatch_cnt <= mismatch_cnt + 3'd1;
                j_out        <= j_nxt;
                k_out        <= k_nxt;
            end
        end
    end

endmodule
